// File: rtl/toggle_hs_pkg.sv
// Shared constants and state encoding for the toggle handshake receiver.
package toggle_hs_pkg;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned CNT_W           = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_VALID = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    VALID = ST_VALID
  } state_e;

endpackage

// File: rtl/toggle_hs_rx_sync.sv
// Multi-flop level synchronizer plus edge-history flop; flags each level change.
// Used on the request path here and on the ack return path in the transmitter.
module toggle_sync
  import toggle_hs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout_sync,
  output logic toggle_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the asynchronous level through the chain and remember the last synced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout_sync  = sync_q[SYNC_STAGES-1];
  assign toggle_det = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase toggle link: sync req, capture word, valid/ready out, ack toggle back.
module toggle_handshake_rx
  import toggle_hs_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_tgl,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overrun
);

  state_e state;
  logic   toggle_det;
  logic   req_sync_unused;

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk       (clk),
    .rst       (rst),
    .din       (req_tgl),
    .dout_sync (req_sync_unused),
    .toggle_det(toggle_det)
  );

  // Capture on a detected toggle, hold until accepted, then flip ack and count.
  // A toggle seen while a word is still pending is dropped and flagged sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ack_tgl    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      evt_count  <= '0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (toggle_det) begin
            dout       <= data_in;
            dout_valid <= 1'b1;
            state      <= VALID;
          end
        end
        VALID: begin
          if (toggle_det) begin
            overrun <= 1'b1;
          end
          if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            ack_tgl    <= ~ack_tgl;
            evt_count  <= evt_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed, table-driven bench for toggle_handshake_rx.
module tb_toggle_handshake_rx;

  logic       clk;
  logic       rst;
  logic       req_tgl;
  logic [7:0] data_in;
  logic       ack_tgl;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] evt_count;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  toggle_handshake_rx #(
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_tgl   (req_tgl),
    .data_in   (data_in),
    .ack_tgl   (ack_tgl),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .evt_count (evt_count),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_dout;
    logic       e_ack;
    logic [7:0] e_cnt;
    logic       e_ovr;
  } vec_t;

  vec_t vec [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [7:0] d,
                           input logic a, input logic [7:0] c, input logic o);
    check({tag, ".valid"}, 32'(dout_valid), 32'(v));
    check({tag, ".dout"},  32'(dout),       32'(d));
    check({tag, ".ack"},   32'(ack_tgl),    32'(a));
    check({tag, ".cnt"},   32'(evt_count),  32'(c));
    check({tag, ".ovr"},   32'(overrun),    32'(o));
  endtask

  initial begin
    logic prev_ack;
    bit   seen;

    // req  data  rdy  valid dout  ack cnt ovr
    vec[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    vec[1]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    vec[2]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 8'd0, 1'b0};
    vec[3]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1, 1'b0};
    vec[4]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1, 1'b0};
    vec[5]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 8'd1, 1'b0};
    vec[6]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 8'd1, 1'b0};
    vec[7]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd1, 1'b0};
    vec[8]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd1, 1'b0};
    vec[9]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd1, 1'b0};
    vec[10] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd1, 1'b0};
    vec[11] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd1, 1'b0};
    vec[12] = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 8'd2, 1'b0};
    vec[13] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 1'b0, 8'd2, 1'b0};
    vec[14] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 1'b0, 8'd2, 1'b0};
    vec[15] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 8'd2, 1'b0};
    vec[16] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 8'd3, 1'b0};

    // Reset held for two cycles
    rst = 1'b0; req_tgl = 1'b0; data_in = 8'h00; dout_ready = 1'b1;
    tick();
    tick();
    check_all("reset", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    tick();
    check_all("post_reset", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);

    // Single transfer, backpressure, opposite-polarity toggle
    for (int i = 0; i < 17; i++) begin
      req_tgl = vec[i].req; data_in = vec[i].data; dout_ready = vec[i].rdy;
      tick();
      check_all($sformatf("vec%0d", i), vec[i].e_valid, vec[i].e_dout,
                vec[i].e_ack, vec[i].e_cnt, vec[i].e_ovr);
    end

    // Overrun: second toggle four cycles after the first while blocked
    dout_ready = 1'b0; data_in = 8'h11; req_tgl = 1'b0;
    tick(); tick(); tick();
    check_all("ovr_first", 1'b1, 8'h11, 1'b1, 8'd3, 1'b0);
    tick();
    data_in = 8'h22; req_tgl = 1'b1;
    tick(); tick(); tick();
    check_all("ovr_flag", 1'b1, 8'h11, 1'b1, 8'd3, 1'b1);
    dout_ready = 1'b1;
    tick();
    check_all("ovr_accept", 1'b0, 8'h11, 1'b0, 8'd4, 1'b1);
    tick(); tick(); tick(); tick();
    check_all("ovr_drop", 1'b0, 8'h11, 1'b0, 8'd4, 1'b1);

    // Asynchronous reset while a word is pending
    dout_ready = 1'b0; data_in = 8'h77; req_tgl = 1'b0;
    tick(); tick(); tick();
    check_all("pre_areset", 1'b1, 8'h77, 1'b0, 8'd4, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_all("areset", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tick(); tick();
    rst = 1'b1; dout_ready = 1'b1;
    tick(); tick(); tick();
    check_all("after_areset", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);

    // 256 back-to-back legal transfers wrap the counter
    for (int i = 0; i < 256; i++) begin
      prev_ack = ack_tgl;
      data_in  = 8'(i ^ 8'h5A);
      req_tgl  = ~req_tgl;
      seen     = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        tick();
        if (ack_tgl !== prev_ack) seen = 1'b1;
      end
      if (!seen) begin
        check($sformatf("wrap_ack_timeout%0d", i), 32'(ack_tgl), 32'(~prev_ack));
      end else begin
        check($sformatf("wrap_dout%0d", i), 32'(dout), 32'(8'(i ^ 8'h5A)));
      end
    end
    tick();
    check_all("wrap_end", 1'b0, 8'(255 ^ 8'h5A), 1'b0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
